// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder sequencer that reuses an external 4-bit ripple adder, one nibble per cycle, LSB first.
// Latency: OUT_VALID rises NIBBLES edges after the accepting edge; accepts every NIBBLES+2 cycles at best.
// Backpressure: IN_READY only in IDLE; the result is held in DONE until OUT_READY, nothing is queued.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [4*NIBBLES-1:0]   OP_A,
    input  logic [4*NIBBLES-1:0]   OP_B,
    input  logic                   CARRY_IN,
    output logic [3:0]             ADD_A,
    output logic [3:0]             ADD_B,
    output logic                   ADD_CIN,
    input  logic [3:0]             ADD_SUM,
    input  logic                   ADD_COUT,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [4*NIBBLES-1:0]   RESULT,
    output logic                   CARRY_OUT
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            carry_reg, carry_nxt;
    logic [W-1:0]    opa_reg, opa_nxt;
    logic [W-1:0]    opb_reg, opb_nxt;
    logic [W-1:0]    result_reg, result_nxt;
    logic            cout_reg, cout_nxt;
    logic            out_vld_reg, out_vld_nxt;
    logic [3:0]      nib_a, nib_b;
    logic            cnt_last;

    // Nibble select straight from registers, so the adder never sees a path from module inputs.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                nib_a = opa_reg[4*i +: 4];
                nib_b = opb_reg[4*i +: 4];
            end
        end
    end

    assign cnt_last = (cnt == CW'(NIBBLES - 1));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        carry_nxt   = carry_reg;
        opa_nxt     = opa_reg;
        opb_nxt     = opb_reg;
        result_nxt  = result_reg;
        cout_nxt    = cout_reg;
        out_vld_nxt = out_vld_reg;
        IN_READY    = 1'b0;
        ADD_A       = 4'h0;
        ADD_B       = 4'h0;
        ADD_CIN     = 1'b0;

        case (state)
            IDLE: begin
                IN_READY = ~RST;
                if (IN_VALID) begin
                    opa_nxt   = OP_A;
                    opb_nxt   = OP_B;
                    carry_nxt = CARRY_IN;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                ADD_A     = nib_a;
                ADD_B     = nib_b;
                ADD_CIN   = carry_reg;
                carry_nxt = ADD_COUT;
                for (int i = 0; i < NIBBLES; i++) begin
                    if (cnt == CW'(i)) begin
                        result_nxt[4*i +: 4] = ADD_SUM;
                    end
                end
                if (cnt_last) begin
                    // Counter parks at zero rather than stepping past the last nibble.
                    cnt_nxt     = '0;
                    cout_nxt    = ADD_COUT;
                    out_vld_nxt = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    out_vld_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            carry_reg   <= 1'b0;
            opa_reg     <= '0;
            opb_reg     <= '0;
            result_reg  <= '0;
            cout_reg    <= 1'b0;
            out_vld_reg <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            carry_reg   <= carry_nxt;
            opa_reg     <= opa_nxt;
            opb_reg     <= opb_nxt;
            result_reg  <= result_nxt;
            cout_reg    <= cout_nxt;
            out_vld_reg <= out_vld_nxt;
        end
    end

    assign OUT_VALID = out_vld_reg;
    assign RESULT    = result_reg;
    assign CARRY_OUT = cout_reg;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl: a 4-nibble instance plus a 1-nibble instance,
// each wired to a behavioural 4-bit adder.
module tb_nibble_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-nibble instance
    logic        in_valid = 1'b0, in_ready, cin = 1'b0;
    logic [15:0] op_a = '0, op_b = '0, result;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout, out_valid, out_ready = 1'b0, carry_out;

    // 1-nibble instance
    logic        n1_in_valid = 1'b0, n1_in_ready, n1_cin = 1'b0;
    logic [3:0]  n1_op_a = '0, n1_op_b = '0, n1_result;
    logic [3:0]  n1_add_a, n1_add_b, n1_add_sum;
    logic        n1_add_cin, n1_add_cout, n1_out_valid, n1_out_ready = 1'b0, n1_carry_out;

    int n_checks = 0;
    int n_fails  = 0;

    assign {add_cout, add_sum}       = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign {n1_add_cout, n1_add_sum} = {1'b0, n1_add_a} + {1'b0, n1_add_b} + {4'b0, n1_add_cin};

    nibble_serial_adder_ctrl #(.NIBBLES(4)) u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .OP_A(op_a), .OP_B(op_b), .CARRY_IN(cin),
        .ADD_A(add_a), .ADD_B(add_b), .ADD_CIN(add_cin),
        .ADD_SUM(add_sum), .ADD_COUT(add_cout),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .RESULT(result), .CARRY_OUT(carry_out)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) u_dut1 (
        .CLK(clk), .RST(rst), .IN_VALID(n1_in_valid), .IN_READY(n1_in_ready),
        .OP_A(n1_op_a), .OP_B(n1_op_b), .CARRY_IN(n1_cin),
        .ADD_A(n1_add_a), .ADD_B(n1_add_b), .ADD_CIN(n1_add_cin),
        .ADD_SUM(n1_add_sum), .ADD_COUT(n1_add_cout),
        .OUT_VALID(n1_out_valid), .OUT_READY(n1_out_ready),
        .RESULT(n1_result), .CARRY_OUT(n1_carry_out)
    );

    // Present a request for one edge; returns at the negedge after the accepting edge.
    task automatic drive_req(input logic [15:0] a, input logic [15:0] b, input logic c);
        @(negedge clk);
        op_a = a; op_b = b; cin = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if ({carry_out, result} !== 17'h0) begin n_fails++; $display("FAIL reset_result got=%h exp=0", {carry_out, result}); end
        n_checks++; if ({add_a, add_b, add_cin} !== 9'h0) begin n_fails++; $display("FAIL reset_add_bus got=%h exp=0", {add_a, add_b, add_cin}); end
        n_checks++; if (n1_in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_n1_in_ready got=%b exp=0", n1_in_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic_add;
        out_ready = 1'b1;
        drive_req(16'h1234, 16'h4321, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL basic_early_valid k=%0d got=%b exp=0", k, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL basic_run_in_ready k=%0d got=%b exp=0", k, in_ready); end
            @(negedge clk);
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fails++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        n_checks++; if (result !== 16'h5555) begin n_fails++; $display("FAIL basic_result got=%h exp=5555", result); end
        n_checks++; if (carry_out !== 1'b0) begin n_fails++; $display("FAIL basic_cout got=%b exp=0", carry_out); end
        n_checks++; if (add_a !== 4'h0) begin n_fails++; $display("FAIL basic_done_add_a got=%h exp=0", add_a); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL basic_idle_ready got=%b exp=1", in_ready); end
        n_checks++; if (result !== 16'h5555) begin n_fails++; $display("FAIL basic_result_kept got=%h exp=5555", result); end
    endtask

    task automatic test_sequencing;
        logic [3:0] exp_a [4] = '{4'hD, 4'hC, 4'hB, 4'hA};
        logic [3:0] exp_b [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        logic       exp_c [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        drive_req(16'hABCD, 16'h1234, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (add_a !== exp_a[k]) begin n_fails++; $display("FAIL seq_add_a k=%0d got=%h exp=%h", k, add_a, exp_a[k]); end
            n_checks++; if (add_b !== exp_b[k]) begin n_fails++; $display("FAIL seq_add_b k=%0d got=%h exp=%h", k, add_b, exp_b[k]); end
            n_checks++; if (add_cin !== exp_c[k]) begin n_fails++; $display("FAIL seq_add_cin k=%0d got=%b exp=%b", k, add_cin, exp_c[k]); end
            @(negedge clk);
        end
        n_checks++; if ({out_valid, carry_out, result} !== {2'b10, 16'hBE01}) begin n_fails++; $display("FAIL seq_result got=%b/%b/%h exp=1/0/be01", out_valid, carry_out, result); end
        @(negedge clk);
    endtask

    task automatic test_carry_ripple;
        out_ready = 1'b1;
        drive_req(16'hFFFF, 16'h0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (add_cin !== (k != 0)) begin n_fails++; $display("FAIL ripple_cin k=%0d got=%b exp=%b", k, add_cin, (k != 0)); end
            @(negedge clk);
        end
        n_checks++; if ({out_valid, carry_out, result} !== {2'b11, 16'h0000}) begin n_fails++; $display("FAIL ripple_result got=%b/%b/%h exp=1/1/0000", out_valid, carry_out, result); end
        @(negedge clk);
        drive_req(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++; if ({out_valid, carry_out, result} !== {2'b11, 16'hFFFF}) begin n_fails++; $display("FAIL ripple_max_result got=%b/%b/%h exp=1/1/ffff", out_valid, carry_out, result); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive_req(16'h1111, 16'h2222, 1'b0);
        repeat (4) @(negedge clk);
        op_a = 16'h2468; op_b = 16'h1357; cin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if ({out_valid, carry_out, result} !== {2'b10, 16'h3333}) begin n_fails++; $display("FAIL bp_hold k=%0d got=%b/%b/%h exp=1/0/3333", k, out_valid, carry_out, result); end
            n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, in_ready); end
            n_checks++; if ({add_a, add_b} !== 8'h00) begin n_fails++; $display("FAIL bp_add_bus k=%0d got=%h exp=00", k, {add_a, add_b}); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fails++; $display("FAIL bp_release got=%b%b exp=01", out_valid, in_ready); end
        n_checks++; if (result !== 16'h3333) begin n_fails++; $display("FAIL bp_result_kept got=%h exp=3333", result); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if ({add_a, add_b} !== 8'h87) begin n_fails++; $display("FAIL bp_new_first_nibble got=%h exp=87", {add_a, add_b}); end
        repeat (4) @(negedge clk);
        n_checks++; if ({out_valid, carry_out, result} !== {2'b10, 16'h37BF}) begin n_fails++; $display("FAIL bp_new_result got=%b/%b/%h exp=1/0/37bf", out_valid, carry_out, result); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        out_ready = 1'b1;
        drive_req(16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({out_valid, carry_out, result} !== 18'h0) begin n_fails++; $display("FAIL rst_mid_outputs got=%b/%b/%h exp=0/0/0000", out_valid, carry_out, result); end
        n_checks++; if ({add_a, add_b, add_cin, in_ready} !== 10'h0) begin n_fails++; $display("FAIL rst_mid_add_bus got=%h exp=0", {add_a, add_b, add_cin, in_ready}); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL rst_mid_ready_after got=%b exp=1", in_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL rst_mid_no_valid k=%0d got=%b exp=0", k, out_valid); end
        end
        drive_req(16'h0F0F, 16'h00F1, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++; if ({out_valid, carry_out, result} !== {2'b10, 16'h1000}) begin n_fails++; $display("FAIL rst_mid_next_result got=%b/%b/%h exp=1/0/1000", out_valid, carry_out, result); end
        @(negedge clk);
    endtask

    task automatic test_nibbles1;
        n1_out_ready = 1'b1;
        @(negedge clk);
        n1_op_a = 4'h9; n1_op_b = 4'h8; n1_cin = 1'b1; n1_in_valid = 1'b1;
        @(negedge clk);
        n1_in_valid = 1'b0;
        n_checks++; if ({n1_out_valid, n1_add_a, n1_add_b, n1_add_cin} !== {1'b0, 4'h9, 4'h8, 1'b1}) begin n_fails++; $display("FAIL n1_run got=%b/%h/%h/%b exp=0/9/8/1", n1_out_valid, n1_add_a, n1_add_b, n1_add_cin); end
        @(negedge clk);
        n_checks++; if ({n1_out_valid, n1_carry_out, n1_result} !== {2'b11, 4'h2}) begin n_fails++; $display("FAIL n1_result got=%b/%b/%h exp=1/1/2", n1_out_valid, n1_carry_out, n1_result); end
        @(negedge clk);
        n_checks++; if ({n1_out_valid, n1_in_ready} !== 2'b01) begin n_fails++; $display("FAIL n1_return_idle got=%b%b exp=01", n1_out_valid, n1_in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_sequencing();
        test_carry_ripple();
        test_backpressure();
        test_reset_mid_op();
        test_nibbles1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d fails=%0d", n_checks, n_fails);
        $fatal(1, "timeout");
    end

endmodule
